logic_unit_seq: RTL

- Parametrised, slice-serial bitwise logic unit; next generation of the fixed 16-bit AND array.
- Operand width is generic and the unit supports four bitwise ops (AND, OR, XOR, NAND).
- Processes SLICE bits per clock under a valid/ready handshake on both input and output.
- Sits between the register file and the ALU result mux, so wide operands reuse a narrow gate array.

---
 rtl/logic_unit_seq.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/logic_unit_seq.sv
`default_nettype none
// ============================================================================
// Module   : logic_unit_seq
// Brief    : Slice-serial bitwise logic unit (AND/OR/XOR/NAND) with
//            valid/ready handshakes; SLICE bits of the result per clock.
//            Optional zero/negative flags when LOGIC_UNIT_FLAGS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module logic_unit_seq #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out
`ifdef LOGIC_UNIT_FLAGS_EN
    ,
    output logic             zr,
    output logic             ng
`endif
);

    localparam int NSLICE  = WIDTH / SLICE;
    localparam int c_cnt_w = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(NSLICE - 1);

    generate
        if (SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_slice
            $error("logic_unit_seq: SLICE must divide WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic                 r_armed;
    logic [WIDTH-1:0]     r_x;
    logic [WIDTH-1:0]     r_y;
    logic [1:0]           r_op;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [WIDTH-1:0]     r_out;
    logic [SLICE-1:0]     w_xs;
    logic [SLICE-1:0]     w_ys;
    logic [SLICE-1:0]     w_slice;
    logic                 w_accept;
    logic                 w_last;

    // in_ready is held low for the first edge after reset release
    assign in_ready  = (r_state == S_IDLE) && r_armed;
    assign out_valid = (r_state == S_DONE);
    assign out       = r_out;
    assign w_accept  = in_valid && in_ready;
    assign w_last    = (r_state == S_RUN) && (r_cnt == c_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)  w_next = S_RUN;
            S_RUN:   if (w_last)    w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default:                w_next = S_IDLE;
        endcase
    end

    // Narrow gate array: select the active operand slice, then apply op
    always_comb begin
        w_xs = '0;
        w_ys = '0;
        for (int i = 0; i < NSLICE; i++) begin
            if (r_cnt == c_cnt_w'(i)) begin
                w_xs = r_x[i*SLICE +: SLICE];
                w_ys = r_y[i*SLICE +: SLICE];
            end
        end
    end

    always_comb begin
        w_slice = '0;
        case (r_op)
            2'b00:   w_slice = w_xs & w_ys;
            2'b01:   w_slice = w_xs | w_ys;
            2'b10:   w_slice = w_xs ^ w_ys;
            default: w_slice = ~(w_xs & w_ys);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_armed <= 1'b0;
            r_x     <= '0;
            r_y     <= '0;
            r_op    <= 2'b00;
            r_cnt   <= '0;
            r_out   <= '0;
        end else begin
            r_armed <= 1'b1;
            if (w_accept) begin
                r_x   <= x;
                r_y   <= y;
                r_op  <= op;
                r_cnt <= '0;
            end else if (r_state == S_RUN) begin
                for (int i = 0; i < NSLICE; i++) begin
                    if (r_cnt == c_cnt_w'(i)) begin
                        r_out[i*SLICE +: SLICE] <= w_slice;
                    end
                end
                r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            end
        end
    end

`ifdef LOGIC_UNIT_FLAGS_EN
    logic [WIDTH-1:0] w_full;
    logic             r_zr;
    logic             r_ng;

    // Full result as it will look after the final slice is written
    always_comb begin
        w_full = r_out;
        w_full[(NSLICE-1)*SLICE +: SLICE] = w_slice;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_zr <= 1'b0;
            r_ng <= 1'b0;
        end else if (w_last) begin
            r_zr <= (w_full == '0);
            r_ng <= w_full[WIDTH-1];
        end
    end

    assign zr = r_zr;
    assign ng = r_ng;
`endif

endmodule
`default_nettype wire
